sipo_frame_rx: RTL and testbench

Serial-to-parallel frame receiver: the receiving end of the team's shift-register serial link. Samples a single-wire bitstream (idle-high, start bit, WIDTH data bits, optional parity, stop bit) on bit-strobe cycles, assembles the word in an internal shift register, and presents it on a valid/ready output port. Sits between the line and any parallel consumer; pairs with the parallel-load/shift-out transmitter on the far end.

---
 rtl/sipo_frame_pkg.sv | 23 ++
 rtl/sipo_frame_rx_if.sv | 32 +++
 rtl/sipo_shift.sv | 32 +++
 rtl/sipo_frame_rx.sv | 144 ++++++++++++++
 tb/tb_sipo_frame_rx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_frame_pkg.sv
// rtl/sipo_frame_pkg.sv - shared types and constants for the serial frame receiver (PARITY_EN_EN adds the parity state)
package sipo_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_STOP      = 3'd2,
        ST_WAIT_IDLE = 3'd3
`ifdef PARITY_EN_EN
        ,
        ST_PARITY    = 3'd4
`endif
    } rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Bit counter must be able to hold WIDTH itself after the last data bit.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// rtl/sipo_frame_rx_if.sv - line-side and word-side signal bundle of the frame receiver
interface sipo_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             ser_in;
    logic             bit_en;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             ready;
    logic             frame_err;
    logic             overrun;

    modport slave (
        input  ser_in,
        input  bit_en,
        input  ready,
        output data_out,
        output valid,
        output frame_err,
        output overrun
    );

    modport master (
        output ser_in,
        output bit_en,
        output ready,
        input  data_out,
        input  valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - WIDTH-bit serial-in shift register with selectable fill direction
module sipo_shift #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    // MSB-first shifts left so the earliest bit ends at the top; LSB-first shifts right.
    generate
        if (MSB_FIRST) begin : g_msb
            assign q_next = {q[WIDTH-2:0], ser_in};
        end else begin : g_lsb
            assign q_next = {ser_in, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - serial frame receiver: start, WIDTH data bits, stop, word on valid/ready
// Build option PARITY_EN_EN inserts an even-parity bit between the data and the stop bit.
module sipo_frame_rx
    import sipo_frame_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sipo_frame_rx_if.slave    bus
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shift_en;
    logic             frame_good;
    logic             frame_bad;
    logic [WIDTH-1:0] shreg;
`ifdef PARITY_EN_EN
    logic             par_err_q, par_err_d;
`endif

    sipo_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .ser_in   (bus.ser_in),
        .q        (shreg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
`ifdef PARITY_EN_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
`ifdef PARITY_EN_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_en   = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
`ifdef PARITY_EN_EN
        par_err_d  = par_err_q;
`endif
        if (bus.bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ser_in == START_LEVEL) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
`ifdef PARITY_EN_EN
                        par_err_d = 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef PARITY_EN_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
`ifdef PARITY_EN_EN
                ST_PARITY: begin
                    // Even parity: data bits XOR parity bit must come out 0.
                    par_err_d = (^shreg) ^ bus.ser_in;
                    state_d   = ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (bus.ser_in == IDLE_LEVEL) begin
                        state_d = ST_IDLE;
`ifdef PARITY_EN_EN
                        frame_good = !par_err_q;
                        frame_bad  = par_err_q;
`else
                        frame_good = 1'b1;
`endif
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    // A line stuck low must not be mistaken for a stream of start bits.
                    if (bus.ser_in == IDLE_LEVEL) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_out  <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= frame_bad;
            if (frame_good) begin
                if (!bus.valid || bus.ready) begin
                    bus.data_out <= shreg;
                    bus.valid    <= 1'b1;
                    if (bus.valid) begin
                        bus.overrun <= 1'b0;
                    end
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (bus.valid && bus.ready) begin
                bus.valid   <= 1'b0;
                bus.overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - bench for sipo_frame_rx, both bit orders side by side (honours PARITY_EN_EN)
module tb_sipo_frame_rx;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ser_in = 1'b1;
    logic bit_en = 1'b0;
    logic ready = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_rx_if #(.WIDTH(W)) bus_m ();
    sipo_frame_rx_if #(.WIDTH(W)) bus_l ();

    assign bus_m.ser_in = ser_in;
    assign bus_m.bit_en = bit_en;
    assign bus_m.ready  = ready;
    assign bus_l.ser_in = ser_in;
    assign bus_l.bit_en = bit_en;
    assign bus_l.ready  = ready;

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    int errors = 0;
    int checks = 0;
    bit rand_rdy = 1'b0;
    bit gaps = 1'b0;
    logic rdy = 1'b0;

    logic [W-1:0] m_data_a = '0;
    logic [W-1:0] m_data_b = '0;
    logic m_valid = 1'b0;
    logic m_err = 1'b0;
    logic m_ovr = 1'b0;

    typedef struct {
        logic [W-1:0] val;
        bit           stop;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        bit           exp_valid;
        bit           exp_err;
    } vec_t;

    vec_t vt[7];

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chkw("msb.data",      bus_m.data_out,  m_data_a);
        chk1("msb.valid",     bus_m.valid,     m_valid);
        chk1("msb.frame_err", bus_m.frame_err, m_err);
        chk1("msb.overrun",   bus_m.overrun,   m_ovr);
        chkw("lsb.data",      bus_l.data_out,  m_data_b);
        chk1("lsb.valid",     bus_l.valid,     m_valid);
        chk1("lsb.frame_err", bus_l.frame_err, m_err);
        chk1("lsb.overrun",   bus_l.overrun,   m_ovr);
    endtask

    task automatic check_explicit(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                                  input logic ev, input logic ee, input logic eo);
        chkw({tag, ".msb.data"},  bus_m.data_out,  ea);
        chkw({tag, ".lsb.data"},  bus_l.data_out,  eb);
        chk1({tag, ".valid"},     bus_m.valid,     ev);
        chk1({tag, ".frame_err"}, bus_m.frame_err, ee);
        chk1({tag, ".overrun"},   bus_m.overrun,   eo);
    endtask

    // One clock: apply line/strobe/ready, advance the output-buffer model, compare after the edge.
    task automatic tick(input logic s, input logic en, input bit good, input bit bad, input logic [W-1:0] v);
        logic hs;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        ser_in = s;
        bit_en = en;
        ready  = rdy;
        hs = m_valid && rdy;
        if (good) begin
            if (!m_valid || rdy) begin
                m_data_a = v;
                m_data_b = rev(v);
                m_valid  = 1'b1;
                if (hs) m_ovr = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        m_err = bad;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic strobe(input logic s, input bit good, input bit bad, input logic [W-1:0] v);
        int n;
        n = gaps ? int'($urandom_range(0, 2)) : 0;
        for (int k = 0; k < n; k++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, v);
        tick(s, 1'b1, good, bad, v);
    endtask

    // Line order: start, v[W-1] .. v[0], [parity], stop.
    task automatic send_frame(input logic [W-1:0] v, input bit stop, input bit par_ok, input logic rdy_stop);
        bit pe;
        bit good;
`ifdef PARITY_EN_EN
        pe = !par_ok;
`else
        pe = 1'b0;
        if (par_ok) pe = 1'b0;
`endif
        good = stop && !pe;
        strobe(1'b0, 1'b0, 1'b0, v);
        for (int i = W - 1; i >= 0; i--) strobe(v[i], 1'b0, 1'b0, v);
`ifdef PARITY_EN_EN
        strobe((^v) ^ pe, 1'b0, 1'b0, v);
`endif
        rdy = rdy_stop;
        strobe(stop, good, !good, v);
    endtask

    initial begin
        vt[0] = '{4'b1101, 1'b1, 4'b1101, 4'b1011, 1'b1, 1'b0};
        vt[1] = '{4'b1001, 1'b0, 4'b1101, 4'b1011, 1'b0, 1'b1};
        vt[2] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vt[3] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0};
        vt[4] = '{4'b0110, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1};
        vt[5] = '{4'b0100, 1'b1, 4'b0100, 4'b0010, 1'b1, 1'b0};
        vt[6] = '{4'b1000, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_explicit("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        rdy = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);

        gaps = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_frame(vt[i].val, vt[i].stop, 1'b1, 1'b1);
            check_explicit($sformatf("vec%0d", i), vt[i].exp_a, vt[i].exp_b,
                           vt[i].exp_valid, vt[i].exp_err, 1'b0);
            rdy = 1'b1;
            tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
            tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        end
        gaps = 1'b0;

        // Bad stop then line held low: no retrigger until it returns high.
        send_frame(4'b1001, 1'b0, 1'b1, 1'b1);
        check_explicit("stop0", 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_explicit("held_low", 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        send_frame(4'b0011, 1'b1, 1'b1, 1'b1);
        check_explicit("after_low", 4'b0011, 4'b1100, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);

        // Overrun with consumer stalled, then one accept clears both.
        rdy = 1'b0;
        send_frame(4'b1001, 1'b1, 1'b1, 1'b0);
        send_frame(4'b0110, 1'b1, 1'b1, 1'b0);
        check_explicit("overrun", 4'b1001, 4'b1001, 1'b1, 1'b0, 1'b1);
        rdy = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_explicit("drain", 4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);

        // Completion in the same cycle as the handshake.
        rdy = 1'b0;
        send_frame(4'b1010, 1'b1, 1'b1, 1'b0);
        send_frame(4'b0101, 1'b1, 1'b1, 1'b1);
        check_explicit("simul", 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);

        // Back-to-back frames with no idle strobe between them.
        send_frame(4'b1100, 1'b1, 1'b1, 1'b1);
        send_frame(4'b0111, 1'b1, 1'b1, 1'b1);
        check_explicit("b2b", 4'b0111, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);

        // Reset after two data bits.
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        rst = 1'b0;
        #2;
        check_explicit("midrst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        m_data_a = '0; m_data_b = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        send_frame(4'b0011, 1'b1, 1'b1, 1'b1);
        check_explicit("postrst", 4'b0011, 4'b1100, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);

`ifdef PARITY_EN_EN
        send_frame(4'b0111, 1'b1, 1'b1, 1'b1);
        check_explicit("par_ok", 4'b0111, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        send_frame(4'b0111, 1'b1, 1'b0, 1'b1);
        check_explicit("par_bad", 4'b0111, 4'b1110, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
`endif

        // Random frames, gaps, stop and parity faults, and a random consumer.
        rand_rdy = 1'b1;
        gaps = 1'b1;
        for (int f = 0; f < 150; f++) begin
            logic [W-1:0] v;
            bit stop;
            bit pok;
            v    = W'($urandom);
            stop = ($urandom_range(0, 6) != 0);
            pok  = ($urandom_range(0, 5) != 0);
            send_frame(v, stop, pok, rdy);
            if (!stop) tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
